// File: rtl/rbm_stochastic_neuron_if.sv
// Operand/result bundle for the stochastic RBM neuron.
// Master drives operands; slave returns the registered neuron outputs.
interface rbm_stochastic_neuron_if #(
    parameter int bitlength         = 12,
    parameter int sigmoid_bitlength = 8,
    parameter int input_dim         = 15
);
    logic                                data_valid;
    logic [input_dim-1:0]                input_bits;
    logic [input_dim*bitlength-1:0]      weights;
    logic signed [bitlength-1:0]         bias;
    logic signed [bitlength-1:0]         sum;
    logic [sigmoid_bitlength-1:0]        prob;
    logic [sigmoid_bitlength-1:0]        rnd;
    logic                                spike;
    logic                                out_valid;

    modport master (
        output data_valid, input_bits, weights, bias,
        input  sum, prob, rnd, spike, out_valid
    );

    modport slave (
        input  data_valid, input_bits, weights, bias,
        output sum, prob, rnd, spike, out_valid
    );
endinterface

// File: rtl/rbm_stochastic_neuron.sv
// Two-stage stochastic RBM neuron: gated weight sum with per-step
// saturation, piecewise-linear sigmoid, LFSR-driven Bernoulli spike.
module rbm_stochastic_neuron #(
    parameter int                   bitlength         = 12,
    parameter int                   sigmoid_bitlength = 8,
    parameter int                   input_dim         = 15,
    parameter logic [bitlength-1:0] Inf               = 12'h7FF,
    parameter logic [7:0]           SEED              = 8'h07
) (
    input logic                   clock,
    input logic                   reset,
    rbm_stochastic_neuron_if.slave nif
);
    typedef logic signed [bitlength-1:0] word_t;
    typedef logic signed [bitlength:0]   wide_t;
    typedef logic [bitlength+1:0]        p_t;
    typedef logic [sigmoid_bitlength-1:0] pr_t;

    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam wide_t      INF_X    = {1'b0, Inf};
    localparam wide_t      NINF_X   = -INF_X;
    localparam pr_t        PMAX     = {sigmoid_bitlength{1'b1}};

    word_t                              bias_q, bias_d;
    logic [input_dim-1:0][bitlength-1:0] g_q, g_d;
    logic                               vs1_q, vs1_d;
    word_t                              sum_q, sum_d;
    pr_t                                prob_q, prob_d;
    logic                               spike_q, spike_d;
    logic                               vout_q, vout_d;
    logic [7:0]                         r_q, r_d;

    word_t                              result;
    logic [bitlength-1:0]               mag;
    p_t                                 p;
    p_t                                 q;
    pr_t                                prob_c;

    function automatic word_t sat_add(input word_t a, input word_t b);
        wide_t s;
        s = wide_t'(a) + wide_t'(b);
        if (s > INF_X)
            return word_t'(INF_X);
        else if (s < NINF_X)
            return word_t'(NINF_X);
        else
            return word_t'(s);
    endfunction

    always_comb begin
        bias_d = bias_q;
        g_d    = g_q;
        vs1_d  = nif.data_valid;
        if (nif.data_valid) begin
            bias_d = nif.bias;
            for (int j = 0; j < input_dim; j++) begin
                g_d[j] = nif.input_bits[j] ?
                         nif.weights[j*bitlength +: bitlength] : '0;
            end
        end
    end

    // Saturate after every addition so the result depends on input order.
    always_comb begin
        result = bias_q;
        for (int j = 0; j < input_dim; j++) begin
            result = sat_add(result, word_t'(g_q[j]));
        end
    end

    always_comb begin
        mag = result[bitlength-1] ? -result : result;
        p   = p_t'(256);
        unique case (1'b1)
            (mag < 16):              p = p_t'({mag, 2'b00}) + p_t'(128);
            (mag >= 16 && mag < 38): p = p_t'({mag, 1'b0}) + p_t'(160);
            (mag >= 38 && mag < 80): p = p_t'(mag >> 1) + p_t'(216);
            (mag >= 80):             p = p_t'(256);
        endcase
        q      = p_t'(256) - p;
        prob_c = '0;
        if (!result[bitlength-1])
            prob_c = (p > p_t'(PMAX)) ? PMAX : pr_t'(p);
        else
            prob_c = (q > p_t'(PMAX)) ? PMAX : pr_t'(q);
    end

    always_comb begin
        sum_d   = sum_q;
        prob_d  = prob_q;
        spike_d = spike_q;
        vout_d  = vs1_q;
        r_d     = {r_q[6:0], r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3]};
        if (vs1_q) begin
            sum_d   = result;
            prob_d  = prob_c;
            spike_d = (prob_c > pr_t'(r_q));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bias_q  <= '0;
            g_q     <= '0;
            vs1_q   <= 1'b0;
            sum_q   <= '0;
            prob_q  <= '0;
            spike_q <= 1'b0;
            vout_q  <= 1'b0;
            r_q     <= SEED_EFF;
        end else begin
            bias_q  <= bias_d;
            g_q     <= g_d;
            vs1_q   <= vs1_d;
            sum_q   <= sum_d;
            prob_q  <= prob_d;
            spike_q <= spike_d;
            vout_q  <= vout_d;
            r_q     <= r_d;
        end
    end

    assign nif.sum       = sum_q;
    assign nif.prob      = prob_q;
    assign nif.spike     = spike_q;
    assign nif.out_valid = vout_q;
    assign nif.rnd       = pr_t'(r_q);
endmodule

// File: tb/tb_rbm_stochastic_neuron.sv
// Scoreboard bench for rbm_stochastic_neuron: real-valued sigmoid model,
// independent LFSR model, reset/latency/saturation/hold scenarios.
module tb_rbm_stochastic_neuron;
    localparam int BL = 12;
    localparam int SB = 8;
    localparam int ND = 15;

    logic clock;
    logic reset;

    rbm_stochastic_neuron_if #(.bitlength(BL), .sigmoid_bitlength(SB),
                               .input_dim(ND)) nif ();

    rbm_stochastic_neuron dut (
        .clock (clock),
        .reset (reset),
        .nif   (nif.slave)
    );

    typedef struct {
        int sum;
        int prob;
        bit spike;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    logic [7:0] m_r;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) m_r <= 8'h07;
        else        m_r <= {m_r[6:0], ^(m_r & 8'hB8)};
    end

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    function automatic int model_prob(input int x);
        real m, f;
        int  pp, r;
        m = ((x < 0) ? -x : x) / 16.0;
        if (m < 1.0)        f = 0.25 * m + 0.5;
        else if (m < 2.375) f = 0.125 * m + 0.625;
        else if (m < 5.0)   f = 0.03125 * m + 0.84375;
        else                f = 1.0;
        pp = int'($floor(256.0 * f));
        if (x >= 0) r = pp;
        else        r = 256 - pp;
        if (r > 255) r = 255;
        if (r < 0)   r = 0;
        return r;
    endfunction

    function automatic int model_sum(input int b, input logic [ND-1:0] bits,
                                     input int w[ND]);
        int acc;
        acc = b;
        for (int j = 0; j < ND; j++) begin
            acc = acc + (bits[j] ? w[j] : 0);
            if (acc > 2047)  acc = 2047;
            if (acc < -2047) acc = -2047;
        end
        return acc;
    endfunction

    // Drive one operand set for one edge; expected result queued now.
    task automatic send(input int b, input logic [ND-1:0] bits,
                        input int w[ND], input int e_sum, input int e_prob);
        exp_t e;
        nif.data_valid = 1'b1;
        nif.bias       = BL'(b);
        nif.input_bits = bits;
        for (int j = 0; j < ND; j++) nif.weights[j*BL +: BL] = BL'(w[j]);
        e.sum   = e_sum;
        e.prob  = e_prob;
        e.spike = (e_prob > int'(lfsr_next(m_r)));
        sb.push_back(e);
        @(negedge clock);
        nif.data_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (sb.size() != 0)
            $display("FAIL drain: %0d outputs missing, required 0", sb.size());
        else
            passes++;
    endtask

    always @(negedge clock) begin
        if (reset && nif.out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_out: out_valid=1 with empty scoreboard");
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (int'(nif.sum) !== e.sum)
                    $display("FAIL sum: got %0d required %0d",
                             int'(nif.sum), e.sum);
                else passes++;
                checks++;
                if (int'(nif.prob) !== e.prob)
                    $display("FAIL prob: got %0d required %0d",
                             int'(nif.prob), e.prob);
                else passes++;
                checks++;
                if (nif.spike !== e.spike)
                    $display("FAIL spike: got %0b required %0b (prob %0d)",
                             nif.spike, e.spike, e.prob);
                else passes++;
            end
        end
    end

    task automatic test_reset();
        reset          = 1'b0;
        nif.data_valid = 1'b1;
        nif.bias       = '0;
        nif.input_bits = '0;
        nif.weights    = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (nif.out_valid !== 1'b0)
            $display("FAIL reset_valid: got %0b required 0", nif.out_valid);
        else passes++;
        checks++;
        if (nif.sum !== '0 || nif.prob !== '0 || nif.spike !== 1'b0)
            $display("FAIL reset_outputs: sum %0d prob %0d spike %0b required 0",
                     nif.sum, nif.prob, nif.spike);
        else passes++;
        checks++;
        if (nif.rnd !== 8'h07)
            $display("FAIL reset_rand: got %h required 07", nif.rnd);
        else passes++;
        nif.data_valid = 1'b0;
    endtask

    task automatic test_lfsr();
        logic [7:0] seq[4];
        seq = '{8'h07, 8'h0E, 8'h1D, 8'h3A};
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (nif.rnd !== seq[i])
                $display("FAIL lfsr_%0d: got %h required %h", i, nif.rnd, seq[i]);
            else passes++;
            checks++;
            if (nif.out_valid !== 1'b0)
                $display("FAIL lfsr_valid_%0d: got %0b required 0",
                         i, nif.out_valid);
            else passes++;
            if (i < 3) @(negedge clock);
        end
    endtask

    task automatic test_zero();
        int w[ND];
        logic v[3];
        foreach (w[j]) w[j] = 0;
        send(0, '0, w, 0, 128);
        v[0] = nif.out_valid;
        @(negedge clock);
        v[1] = nif.out_valid;
        @(negedge clock);
        v[2] = nif.out_valid;
        checks++;
        if (v[0] !== 1'b0 || v[1] !== 1'b1 || v[2] !== 1'b0)
            $display("FAIL valid_pulse: got %0b%0b%0b required 010",
                     v[0], v[1], v[2]);
        else passes++;
    endtask

    task automatic test_single();
        int wt[5];
        int pr[5];
        int w[ND];
        int idx;
        wt = '{16, 8, 38, -16, 80};
        pr = '{192, 160, 235, 64, 255};
        for (int k = 0; k < 5; k++) begin
            foreach (w[j]) w[j] = 0;
            idx = (k * 4) % ND;
            w[idx] = wt[k];
            w[(idx + 1) % ND] = 500;
            send(0, ND'(1) << idx, w, wt[k], pr[k]);
            @(negedge clock);
        end
        drain();
    endtask

    task automatic test_saturation();
        int w[ND];
        foreach (w[j]) w[j] = 0;
        w[0] = 100;
        send(2000, ND'(1), w, 2047, 255);
        w[0] = -100;
        send(-2000, ND'(1), w, -2047, 0);
        foreach (w[j]) w[j] = 0;
        w[0] = 20;
        w[1] = -20;
        send(2040, ND'(3), w, 2027, 255);
        drain();
    endtask

    task automatic test_back_to_back();
        int w[ND];
        int b;
        logic [ND-1:0] bits;
        int s;
        for (int n = 0; n < 24; n++) begin
            foreach (w[j]) w[j] = int'($urandom_range(160)) - 80;
            if (n % 6 == 5) w[3] = 1500;
            b    = int'($urandom_range(200)) - 100;
            bits = ND'($urandom);
            s    = model_sum(b, bits, w);
            send(b, bits, w, s, model_prob(s));
        end
        drain();
    endtask

    task automatic test_hold();
        int w[ND];
        logic [BL-1:0] s0;
        logic [SB-1:0] p0;
        logic          k0;
        foreach (w[j]) w[j] = 0;
        w[2] = 30;
        send(-5, ND'(4), w, 25, model_prob(25));
        drain();
        s0 = nif.sum;
        p0 = nif.prob;
        k0 = nif.spike;
        repeat (4) begin
            @(negedge clock);
            checks++;
            if (nif.out_valid !== 1'b0 || nif.sum !== s0 ||
                nif.prob !== p0 || nif.spike !== k0)
                $display("FAIL hold: valid %0b sum %0d prob %0d spike %0b required 0 %0d %0d %0b",
                         nif.out_valid, nif.sum, nif.prob, nif.spike, s0, p0, k0);
            else passes++;
        end
    endtask

    task automatic test_reset_midflight();
        int w[ND];
        foreach (w[j]) w[j] = 0;
        w[0] = 64;
        nif.data_valid = 1'b1;
        nif.bias       = BL'(100);
        nif.input_bits = ND'(1);
        for (int j = 0; j < ND; j++) nif.weights[j*BL +: BL] = BL'(w[j]);
        @(negedge clock);
        nif.data_valid = 1'b0;
        reset = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (nif.out_valid !== 1'b0 || nif.sum !== '0 ||
            nif.prob !== '0 || nif.spike !== 1'b0)
            $display("FAIL midflight_clear: valid %0b sum %0d prob %0d spike %0b required 0",
                     nif.out_valid, nif.sum, nif.prob, nif.spike);
        else passes++;
        checks++;
        if (nif.rnd !== 8'h07)
            $display("FAIL midflight_rand: got %h required 07", nif.rnd);
        else passes++;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (nif.out_valid !== 1'b0)
                $display("FAIL midflight_valid: got %0b required 0", nif.out_valid);
            else passes++;
        end
    endtask

    initial begin
        nif.data_valid = 1'b0;
        nif.bias       = '0;
        nif.input_bits = '0;
        nif.weights    = '0;
        reset          = 1'b0;
        @(negedge clock);
        test_reset();
        test_lfsr();
        @(negedge clock);
        test_zero();
        test_single();
        test_saturation();
        test_back_to_back();
        test_hold();
        test_reset_midflight();
        test_zero();
        drain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/rbm_stochastic_neuron.md
RBM_STOCHASTIC_NEURON -- requirements
Module: rbm_stochastic_neuron

Interface
REQ-001 Parameters, one per line: bitlength, 12, signed accumulator/weight width; sigmoid_bitlength, 8, probability and random-number width; input_dim, 15, number of binary inputs; Inf, 12'h7FF, saturation magnitude; SEED, 8'h07, LFSR reset value.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 data_valid  input  1  operands present this cycle.
REQ-005 input_bits  input  input_dim  binary visible states; bit j gates weight j.
REQ-006 weights  input  input_dim*bitlength  signed weights, weight j at bits [j*bitlength +: bitlength].
REQ-007 bias  input  bitlength  signed bias.
REQ-008 sum  output  bitlength  registered saturated pre-activation.
REQ-009 prob  output  sigmoid_bitlength  registered sigmoid probability.
REQ-010 rand  output  sigmoid_bitlength  current LFSR value.
REQ-011 spike  output  1  registered stochastic neuron state.
REQ-012 out_valid  output  1  sum, prob and spike valid for this cycle.

Function
REQ-013 Fixed point: sum and all adder operands are signed with 4 fractional bits (16 = 1.0); prob is unsigned, 256 = 1.0.
REQ-014 Stage 1: on an edge with data_valid=1, register bias and every gated operand g_j (weight j if input_bits[j]=1, else 0); out_valid_s1 <= data_valid.
REQ-015 Combinational chain from stage-1 registers: s0 = sat(bias + g_0); s_j = sat(s_(j-1) + g_j) for j = 1..input_dim-1; result = s_(input_dim-1), saturating after every step in this order.
REQ-016 sat(a+b): exact sum formed at bitlength+1 bits; result Inf if sum > Inf, -Inf if sum < -Inf, otherwise sum; -2048 is never produced.
REQ-017 Sigmoid on result x with magnitude m = |x|/16: f = 0.25m+0.5 for m<1; 0.125m+0.625 for 1<=m<2.375; 0.03125m+0.84375 for 2.375<=m<5; 1.0 for m>=5.
REQ-018 Let P = floor(256*f). For x>=0, prob = min(P,255); for x<0, prob = 256-P, clamped to 0..255.
REQ-019 LFSR: 8-bit; every clock edge it updates r <= {r[6:0], r[7]^r[5]^r[4]^r[3]}; it is not gated by data_valid; rand = r.
REQ-020 Stage 2: on every edge, sum <= result, prob <= sigmoid(result), spike <= (sigmoid(result) > rand) using the pre-edge rand value, out_valid <= out_valid_s1.
REQ-021 Latency: operands sampled at edge k give outputs and out_valid=1 after edge k+1; back-to-back data_valid yields one output per cycle.
REQ-022 When out_valid=0, sum, prob and spike hold their last values.
REQ-023 Comparison is unsigned and strict, so prob=0 never spikes and prob=255 spikes unless rand=255.

Reset
REQ-024 While reset=0, regardless of clock, clear all stage-1 registers, sum, prob, spike, out_valid_s1 and out_valid to 0, and set r to SEED (8'h01 if SEED=0).
REQ-025 Reset asserted mid-operation discards in-flight data; the first out_valid after release requires a fresh data_valid sample.
REQ-026 data_valid is ignored while reset=0.

Verification
REQ-027 Release reset, no data_valid -> rand = 0x07, then 0x0E, 0x1D, 0x3A on successive edges; out_valid stays 0.
REQ-028 bias=0, input_bits=0 -> one cycle later: sum=0, prob=128, out_valid=1 for exactly one cycle.
REQ-029 Single active input, bias=0: weight 16 -> prob 192; weight 8 -> prob 160; weight 38 -> prob 235; weight -16 -> prob 64; weight 80 -> prob 255.
REQ-030 Saturation: bias=2000, input_bits[0]=1, weight0=100 -> sum=2047, prob=255, spike=1 when rand<255. Negative saturation: bias=-2000, weight0=-100 -> sum=-2047, prob=0, spike=0.
REQ-031 Chain order: bias=2040, w0=+20, w1=-20, bits 0 and 1 set -> sum=2027, not 2040.
REQ-032 Reset asserted between data_valid and output -> out_valid, sum, prob and spike read 0; rand returns to 0x07.
